// File: rtl/bc_sched_pkg.sv
// Shared types and constants for the block-checker session scheduler.
package bc_sched_pkg;

   localparam int unsigned N_REQ           = 2;
   localparam int unsigned CH_W            = 8;
   localparam int unsigned LEN_W           = 8;
   localparam int unsigned MAX_LEN_DEFAULT = 255;

   localparam logic [CH_W-1:0] CH_SPACE    = 8'h20;
   localparam logic [CH_W-1:0] EOS_DEFAULT = 8'h0A;

   // One-hot session state encoding
   typedef enum logic [4:0] {
      ST_IDLE    = 5'b00001,
      ST_CLEAR   = 5'b00010,
      ST_STREAM  = 5'b00100,
      ST_SAMPLE  = 5'b01000,
      ST_RESPOND = 5'b10000
   } state_t;

endpackage

// File: rtl/block_check_sched_rr_arb2.sv
// Two-way round-robin arbiter; a lone requester always wins.
module rr_arb2
   import bc_sched_pkg::*;
(
   input  logic [1:0] req,
   input  logic       last,
   output logic       grant_valid,
   output logic       grant_idx
);

   // Contention goes to the requester not served last
   always_comb begin
      grant_valid = |req;
      grant_idx   = 1'b0;
      if (req == 2'b11) begin
         grant_idx = ~last;
      end else if (req[1]) begin
         grant_idx = 1'b1;
      end
   end

endmodule

// File: rtl/block_check_sched.sv
// Session scheduler sharing one begin/end nesting checker between two requesters.
module block_check_sched
   import bc_sched_pkg::*;
#(
   parameter int unsigned     MAX_LEN = MAX_LEN_DEFAULT,
   parameter logic [CH_W-1:0] EOS     = EOS_DEFAULT
)
(
   input  logic        clk,
   input  logic        reset,
   input  logic [1:0]  req_valid,
   input  logic [15:0] req_data,
   output logic [1:0]  req_ready,
   output logic [1:0]  rsp_valid,
   output logic        rsp_ok,
   output logic [7:0]  rsp_len,
   output logic        busy,
   output logic        owner,
   output logic        chk_reset,
   output logic        chk_en,
   output logic [7:0]  chk_in,
   input  logic        chk_result
);

   localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN);

   state_t            state_q, state_d;
   logic              owner_q, owner_d;
   logic              last_owner_q, last_owner_d;
   logic [LEN_W-1:0]  len_q, len_d;
   logic              overflow_q, overflow_d;
   logic              ok_q, ok_d;

   logic              grant_valid;
   logic              grant_idx;
   logic              sel_valid;
   logic [CH_W-1:0]   sel_char;
   logic [1:0]        owner_onehot;

   rr_arb2 u_arb (
      .req         (req_valid),
      .last        (last_owner_q),
      .grant_valid (grant_valid),
      .grant_idx   (grant_idx)
   );

   assign sel_valid    = owner_q ? req_valid[1] : req_valid[0];
   assign sel_char     = owner_q ? req_data[15:8] : req_data[7:0];
   assign owner_onehot = owner_q ? 2'b10 : 2'b01;

   assign busy      = (state_q != ST_IDLE);
   assign owner     = owner_q;
   assign chk_reset = reset | (state_q == ST_CLEAR);

   // Session state and datapath registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         owner_q      <= 1'b0;
         last_owner_q <= 1'b1;
         len_q        <= '0;
         overflow_q   <= 1'b0;
         ok_q         <= 1'b0;
      end else begin
         state_q      <= state_d;
         owner_q      <= owner_d;
         last_owner_q <= last_owner_d;
         len_q        <= len_d;
         overflow_q   <= overflow_d;
         ok_q         <= ok_d;
      end
   end

   // Next-state, datapath updates and decoded outputs
   always_comb begin
      state_d      = state_q;
      owner_d      = owner_q;
      last_owner_d = last_owner_q;
      len_d        = len_q;
      overflow_d   = overflow_q;
      ok_d         = ok_q;
      req_ready    = 2'b00;
      rsp_valid    = 2'b00;
      rsp_ok       = 1'b0;
      rsp_len      = '0;
      chk_en       = 1'b0;
      chk_in       = CH_SPACE;

      case (state_q)
         ST_IDLE: begin
            if (grant_valid) begin
               owner_d = grant_idx;
               state_d = ST_CLEAR;
            end
         end
         ST_CLEAR: begin
            len_d      = '0;
            overflow_d = 1'b0;
            state_d    = ST_STREAM;
         end
         ST_STREAM: begin
            req_ready = owner_onehot;
            if (sel_valid) begin
               if (sel_char == EOS) begin
                  // Trailing space closes the final token in the checker
                  chk_en  = 1'b1;
                  state_d = ST_SAMPLE;
               end else if (len_q < MAX_LEN_L) begin
                  chk_en = 1'b1;
                  chk_in = sel_char;
                  len_d  = len_q + LEN_W'(1);
               end else begin
                  overflow_d = 1'b1;
               end
            end
         end
         ST_SAMPLE: begin
            ok_d    = chk_result & ~overflow_q;
            state_d = ST_RESPOND;
         end
         ST_RESPOND: begin
            rsp_valid    = owner_onehot;
            rsp_ok       = ok_q;
            rsp_len      = len_q;
            last_owner_d = owner_q;
            state_d      = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_block_check_sched.sv
// Self-checking bench: default instance plus a MAX_LEN=4 instance, each with a checker model.
module tb_block_check_sched;

   typedef struct packed {
      logic [1:0] v;
      logic       ok;
      logic [7:0] len;
   } rsp_t;

   localparam logic [63:0] TOK_BEGIN = 64'h0000_0062_6567_696e;
   localparam logic [63:0] TOK_END   = 64'h0000_0000_0065_6e64;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [1:0]  req_valid_w  [2];
   logic [15:0] req_data_w   [2];
   logic [1:0]  req_ready_w  [2];
   logic [1:0]  rsp_valid_w  [2];
   logic        rsp_ok_w     [2];
   logic [7:0]  rsp_len_w    [2];
   logic        busy_w       [2];
   logic        owner_w      [2];
   logic        chk_reset_w  [2];
   logic        chk_en_w     [2];
   logic [7:0]  chk_in_w     [2];
   logic        chk_result_w [2];

   logic [63:0] tok    [2];
   int          depth  [2];
   bit          err    [2];
   int          en_cnt [2] = '{0, 0};
   int          rsp_cnt[2] = '{0, 0};
   int          cyc = 0;
   bit          watch_r1 = 1'b0;
   int          r1_viol = 0;

   int          n_checks = 0;
   int          n_errors = 0;
   rsp_t        exp_q[$];

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   block_check_sched dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid_w[0]), .req_data(req_data_w[0]), .req_ready(req_ready_w[0]),
      .rsp_valid(rsp_valid_w[0]), .rsp_ok(rsp_ok_w[0]), .rsp_len(rsp_len_w[0]),
      .busy(busy_w[0]), .owner(owner_w[0]),
      .chk_reset(chk_reset_w[0]), .chk_en(chk_en_w[0]), .chk_in(chk_in_w[0]),
      .chk_result(chk_result_w[0])
   );

   block_check_sched #(.MAX_LEN(4)) dut4 (
      .clk(clk), .reset(reset),
      .req_valid(req_valid_w[1]), .req_data(req_data_w[1]), .req_ready(req_ready_w[1]),
      .rsp_valid(rsp_valid_w[1]), .rsp_ok(rsp_ok_w[1]), .rsp_len(rsp_len_w[1]),
      .busy(busy_w[1]), .owner(owner_w[1]),
      .chk_reset(chk_reset_w[1]), .chk_en(chk_en_w[1]), .chk_in(chk_in_w[1]),
      .chk_result(chk_result_w[1])
   );

   // Begin/end nesting checker model: space-delimited tokens, underflow is sticky
   always @(posedge clk) begin
      for (int k = 0; k < 2; k++) begin
         if (chk_reset_w[k]) begin
            tok[k]   <= '0;
            depth[k] <= 0;
            err[k]   <= 1'b0;
         end else if (chk_en_w[k]) begin
            en_cnt[k] <= en_cnt[k] + 1;
            if (chk_in_w[k] == 8'h20) begin
               if (tok[k] == TOK_BEGIN) depth[k] <= depth[k] + 1;
               else if (tok[k] == TOK_END) begin
                  if (depth[k] == 0) err[k] <= 1'b1;
                  else depth[k] <= depth[k] - 1;
               end
               tok[k] <= '0;
            end else begin
               tok[k] <= {tok[k][55:0], chk_in_w[k]};
            end
         end
      end
   end

   always_comb begin
      for (int k = 0; k < 2; k++)
         chk_result_w[k] = !err[k] && (depth[k] == 0) && (tok[k] == 64'd0);
   end

   // Response pulse counter and requester-1 grant leak watch
   always @(negedge clk) begin
      for (int k = 0; k < 2; k++)
         if (rsp_valid_w[k] !== 2'b00) rsp_cnt[k] = rsp_cnt[k] + 1;
      if (watch_r1 && req_ready_w[0][1] !== 1'b0) r1_viol = r1_viol + 1;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic drive_char(input int inst, input int r, input logic [7:0] ch,
                             output int hs, output bit to);
      int n = 0;
      to = 1'b0;
      hs = 0;
      req_data_w[inst][r*8 +: 8] = ch;
      req_valid_w[inst][r] = 1'b1;
      while (req_ready_w[inst][r] !== 1'b1 && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (n >= 50) begin
         to = 1'b1;
         req_valid_w[inst][r] = 1'b0;
         return;
      end
      hs = cyc;
      @(negedge clk);
      req_valid_w[inst][r] = 1'b0;
   endtask

   task automatic send_string(input int inst, input int r, input string s, input int gap,
                              output int hs_last, output bit to);
      int hs;
      to = 1'b0;
      hs_last = 0;
      for (int i = 0; i < s.len(); i++) begin
         drive_char(inst, r, s[i], hs, to);
         if (to) return;
         hs_last = hs;
         if (i != s.len() - 1) repeat (gap) @(negedge clk);
      end
   endtask

   task automatic wait_rsp(input int inst, output rsp_t o, output int at, output bit to);
      int n = 0;
      while (rsp_valid_w[inst] === 2'b00 && n < 20) begin
         @(negedge clk);
         n++;
      end
      to = (n >= 20);
      at = cyc;
      o  = rsp_t'{rsp_valid_w[inst], rsp_ok_w[inst], rsp_len_w[inst]};
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (3) @(negedge clk);
      n_checks++; if (req_ready_w[0] !== 2'b00) begin n_errors++; $display("FAIL reset_req_ready: got %b want 00", req_ready_w[0]); end
      n_checks++; if (rsp_valid_w[0] !== 2'b00) begin n_errors++; $display("FAIL reset_rsp_valid: got %b want 00", rsp_valid_w[0]); end
      n_checks++; if (rsp_ok_w[0] !== 1'b0 || rsp_len_w[0] !== 8'd0) begin n_errors++; $display("FAIL reset_rsp_data: got ok=%b len=%0d want 0/0", rsp_ok_w[0], rsp_len_w[0]); end
      n_checks++; if (busy_w[0] !== 1'b0 || owner_w[0] !== 1'b0) begin n_errors++; $display("FAIL reset_busy_owner: got %b/%b want 0/0", busy_w[0], owner_w[0]); end
      n_checks++; if (chk_en_w[0] !== 1'b0 || chk_in_w[0] !== 8'h20) begin n_errors++; $display("FAIL reset_chk_in: got en=%b in=%h want 0/20", chk_en_w[0], chk_in_w[0]); end
      n_checks++; if (chk_reset_w[0] !== 1'b1) begin n_errors++; $display("FAIL reset_chk_reset: got %b want 1", chk_reset_w[0]); end
      reset = 1'b0;
      @(negedge clk);
      n_checks++; if (chk_reset_w[0] !== 1'b0 || busy_w[0] !== 1'b0) begin n_errors++; $display("FAIL idle_after_reset: got chk_reset=%b busy=%b want 0/0", chk_reset_w[0], busy_w[0]); end
   endtask

   task automatic test_single_r0();
      int hs, at; bit to_s, to_r; rsp_t o, e;
      exp_q.push_back(rsp_t'{2'b01, 1'b1, 8'd9});
      send_string(0, 0, "begin end\n", 0, hs, to_s);
      wait_rsp(0, o, at, to_r);
      e = exp_q.pop_front();
      n_checks++; if (to_s || to_r) begin n_errors++; $display("FAIL single_timeout: send=%b rsp=%b want 0/0", to_s, to_r); end
      n_checks++; if (o.v !== e.v) begin n_errors++; $display("FAIL single_rsp_valid: got %b want %b", o.v, e.v); end
      n_checks++; if (o.ok !== e.ok || o.len !== e.len) begin n_errors++; $display("FAIL single_rsp: got ok=%b len=%0d want ok=%b len=%0d", o.ok, o.len, e.ok, e.len); end
      n_checks++; if (at !== hs + 2) begin n_errors++; $display("FAIL single_latency: got cycle %0d want %0d", at, hs + 2); end
      @(negedge clk);
      n_checks++; if (busy_w[0] !== 1'b0 || rsp_valid_w[0] !== 2'b00) begin n_errors++; $display("FAIL single_idle: got busy=%b rsp_valid=%b want 0/00", busy_w[0], rsp_valid_w[0]); end
   endtask

   task automatic test_gap_r1();
      int hs, at; bit to_s, to_r; rsp_t o, e;
      for (int g = 1; g >= 0; g--) begin
         exp_q.push_back(rsp_t'{2'b10, 1'b0, 8'd15});
         send_string(0, 1, "begin begin end\n", g, hs, to_s);
         wait_rsp(0, o, at, to_r);
         e = exp_q.pop_front();
         n_checks++; if (to_s || to_r) begin n_errors++; $display("FAIL gap%0d_timeout: send=%b rsp=%b want 0/0", g, to_s, to_r); end
         n_checks++; if (o !== e) begin n_errors++; $display("FAIL gap%0d_rsp: got v=%b ok=%b len=%0d want v=%b ok=%b len=%0d", g, o.v, o.ok, o.len, e.v, e.ok, e.len); end
         n_checks++; if (owner_w[0] !== 1'b1) begin n_errors++; $display("FAIL gap%0d_owner: got %b want 1", g, owner_w[0]); end
         @(negedge clk);
      end
   endtask

   task automatic test_both_valid();
      int hs, at; bit to_s, to_r; rsp_t o, e;
      reset = 1'b1;
      req_data_w[0] = {8'h65, 8'h65};
      req_valid_w[0] = 2'b11;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      watch_r1 = 1'b1;
      exp_q.push_back(rsp_t'{2'b01, 1'b0, 8'd3});
      exp_q.push_back(rsp_t'{2'b10, 1'b0, 8'd3});
      send_string(0, 0, "end\n", 0, hs, to_s);
      wait_rsp(0, o, at, to_r);
      watch_r1 = 1'b0;
      e = exp_q.pop_front();
      n_checks++; if (to_s || to_r) begin n_errors++; $display("FAIL both0_timeout: send=%b rsp=%b want 0/0", to_s, to_r); end
      n_checks++; if (o !== e) begin n_errors++; $display("FAIL both0_rsp: got v=%b ok=%b len=%0d want v=%b ok=%b len=%0d", o.v, o.ok, o.len, e.v, e.ok, e.len); end
      n_checks++; if (r1_viol !== 0) begin n_errors++; $display("FAIL both0_ready1: got %0d cycles with req_ready[1]=1 want 0", r1_viol); end
      @(negedge clk);
      send_string(0, 1, "end\n", 0, hs, to_s);
      wait_rsp(0, o, at, to_r);
      e = exp_q.pop_front();
      n_checks++; if (to_s || to_r) begin n_errors++; $display("FAIL both1_timeout: send=%b rsp=%b want 0/0", to_s, to_r); end
      n_checks++; if (o !== e) begin n_errors++; $display("FAIL both1_rsp: got v=%b ok=%b len=%0d want v=%b ok=%b len=%0d", o.v, o.ok, o.len, e.v, e.ok, e.len); end
      @(negedge clk);
   endtask

   task automatic test_overflow();
      int hs, at, en0; bit to_s, to_r; rsp_t o, e;
      en0 = en_cnt[1];
      exp_q.push_back(rsp_t'{2'b01, 1'b0, 8'd4});
      send_string(1, 0, "begin end\n", 0, hs, to_s);
      wait_rsp(1, o, at, to_r);
      e = exp_q.pop_front();
      n_checks++; if (to_s || to_r) begin n_errors++; $display("FAIL ovf_timeout: send=%b rsp=%b want 0/0", to_s, to_r); end
      n_checks++; if (o !== e) begin n_errors++; $display("FAIL ovf_rsp: got v=%b ok=%b len=%0d want v=%b ok=%b len=%0d", o.v, o.ok, o.len, e.v, e.ok, e.len); end
      n_checks++; if (en_cnt[1] - en0 !== 5) begin n_errors++; $display("FAIL ovf_chk_en: got %0d enables want 5", en_cnt[1] - en0); end
      n_checks++; if (at !== hs + 2) begin n_errors++; $display("FAIL ovf_latency: got cycle %0d want %0d", at, hs + 2); end
      @(negedge clk);
   endtask

   task automatic test_empty();
      int hs, at; bit to_s, to_r; rsp_t o, e;
      exp_q.push_back(rsp_t'{2'b01, 1'b1, 8'd0});
      send_string(0, 0, "\n", 0, hs, to_s);
      wait_rsp(0, o, at, to_r);
      e = exp_q.pop_front();
      n_checks++; if (to_s || to_r) begin n_errors++; $display("FAIL empty_timeout: send=%b rsp=%b want 0/0", to_s, to_r); end
      n_checks++; if (o !== e) begin n_errors++; $display("FAIL empty_rsp: got v=%b ok=%b len=%0d want v=%b ok=%b len=%0d", o.v, o.ok, o.len, e.v, e.ok, e.len); end
      n_checks++; if (at !== hs + 2) begin n_errors++; $display("FAIL empty_latency: got cycle %0d want %0d", at, hs + 2); end
      @(negedge clk);
   endtask

   task automatic test_reset_mid();
      int hs, at, en0, rc0; bit to_s, to_r; rsp_t o, e;
      send_string(0, 0, "beg", 0, hs, to_s);
      n_checks++; if (to_s) begin n_errors++; $display("FAIL mid_prefix_timeout: got 1 want 0"); end
      en0 = en_cnt[0];
      rc0 = rsp_cnt[0];
      req_data_w[0][7:0] = 8'h69;
      req_valid_w[0][0] = 1'b1;
      reset = 1'b1;
      #1;
      n_checks++; if (req_ready_w[0] !== 2'b00 || chk_reset_w[0] !== 1'b1) begin n_errors++; $display("FAIL mid_reset_outputs: got ready=%b chk_reset=%b want 00/1", req_ready_w[0], chk_reset_w[0]); end
      @(negedge clk);
      n_checks++; if (busy_w[0] !== 1'b0 || rsp_valid_w[0] !== 2'b00) begin n_errors++; $display("FAIL mid_reset_state: got busy=%b rsp_valid=%b want 0/00", busy_w[0], rsp_valid_w[0]); end
      @(negedge clk);
      reset = 1'b0;
      req_valid_w[0] = 2'b00;
      repeat (4) @(negedge clk);
      n_checks++; if (en_cnt[0] !== en0) begin n_errors++; $display("FAIL mid_pending_consumed: got %0d enables want %0d", en_cnt[0], en0); end
      n_checks++; if (rsp_cnt[0] !== rc0) begin n_errors++; $display("FAIL mid_no_rsp: got %0d pulses want %0d", rsp_cnt[0], rc0); end
      exp_q.push_back(rsp_t'{2'b01, 1'b1, 8'd9});
      send_string(0, 0, "begin end\n", 0, hs, to_s);
      wait_rsp(0, o, at, to_r);
      e = exp_q.pop_front();
      n_checks++; if (to_s || to_r) begin n_errors++; $display("FAIL mid_after_timeout: send=%b rsp=%b want 0/0", to_s, to_r); end
      n_checks++; if (o !== e) begin n_errors++; $display("FAIL mid_after_rsp: got v=%b ok=%b len=%0d want v=%b ok=%b len=%0d", o.v, o.ok, o.len, e.v, e.ok, e.len); end
      @(negedge clk);
   endtask

   initial begin
      for (int k = 0; k < 2; k++) begin
         req_valid_w[k] = 2'b00;
         req_data_w[k]  = 16'h0000;
      end
      test_reset();
      test_single_r0();
      test_gap_r1();
      test_both_valid();
      test_overflow();
      test_empty();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
